wb_stage_buffered: RTL and testbench

//  Next-generation writeback stage, the last pipeline stage after MEM. Accepts retiring instructions over
//  the valid/allow_in handshake into a DEPTH-entry in-order writeback buffer and drains one entry per cycle
//  to the regfile write port whenever rf_w_ready is high. Load results are extracted at enqueue:

---
 rtl/wb_stage_buffered_pkg.sv | 24 ++
 rtl/wb_load_align.sv | 40 ++++
 rtl/wb_stage_buffered.sv | 188 ++++++++++++++++++
 tb/tb_wb_stage_buffered.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_buffered_pkg.sv
// Shared definitions for the buffered writeback stage.
//   - Default datapath and register-address widths.
//   - Load-size codes carried on in_ld_size.
//   - wb_entry_t: the field layout of one writeback buffer entry
//     (pc, write enable, destination register, final write data) at the
//     default widths. The top level mirrors this layout at its own
//     parameterised widths.
package wb_stage_buffered_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int RA_W_DEFAULT = 5;

    localparam logic [1:0] LD_B = 2'b00;
    localparam logic [1:0] LD_H = 2'b01;
    localparam logic [1:0] LD_W = 2'b10;

    typedef struct packed {
        logic [31:0]               pc;
        logic                      w_en;
        logic [RA_W_DEFAULT-1:0]   addr;
        logic [XLEN_DEFAULT-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load-data extraction and extension.
// Ports:
//   rdata        in   raw data RAM word
//   size         in   LD_B / LD_H / LD_W (2'b11 also treated as word)
//   ld_unsigned  in   1 = zero-extend, 0 = sign-extend
//   offset       in   address[1:0]; offset[0] ignored for halves,
//                     whole offset ignored for words
//   data         out  aligned, extended result
module wb_load_align
    import wb_stage_buffered_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      size,
    input  logic            ld_unsigned,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_fill;
    logic        half_fill;

    assign byte_sel  = rdata[{offset, 3'b000} +: 8];
    assign half_sel  = rdata[{offset[1], 4'b0000} +: 16];
    assign byte_fill = byte_sel[7] & ~ld_unsigned;
    assign half_fill = half_sel[15] & ~ld_unsigned;

    always_comb begin
        data = rdata;
        case (size)
            LD_B:    data = {{(XLEN-8){byte_fill}}, byte_sel};
            LD_H:    data = {{(XLEN-16){half_fill}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage_buffered.sv
// Buffered writeback stage: last pipeline stage after MEM.
// Retiring instructions are accepted over mem_to_wb_valid/wb_allow_in into
// an in-order DEPTH-entry buffer; the head drains to the regfile port on
// every cycle rf_w_ready is high. Load data is aligned and extended before
// it is stored, so every buffered entry already holds its final value and
// can be forwarded through the bypass ports without a not-ready state.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   mem_to_wb_valid / wb_allow_in   enqueue handshake
//   in_*                            incoming instruction fields
//   rf_w_ready                      regfile port free this cycle
//   rf_w_en/addr/data               regfile write (addr/data show the head)
//   by_raddr / by_hit / by_data     NUM_BY bypass queries (youngest match)
//   retire_cnt                      retired-instruction counter (wraps)
//   debug_wb_*                      trace view of the retiring entry
module wb_stage_buffered
    import wb_stage_buffered_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int RA_W   = RA_W_DEFAULT,
    parameter int DEPTH  = 2,
    parameter int NUM_BY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_to_wb_valid,
    output logic                   wb_allow_in,
    input  logic [31:0]            in_pc,
    input  logic                   in_rf_w_en,
    input  logic [RA_W-1:0]        in_rf_w_addr,
    input  logic                   in_sel_ram,
    input  logic [XLEN-1:0]        in_alu_result,
    input  logic [XLEN-1:0]        in_ram_rdata,
    input  logic [1:0]             in_ld_size,
    input  logic                   in_ld_unsigned,
    input  logic [1:0]             in_ld_offset,
    input  logic                   rf_w_ready,
    output logic                   rf_w_en,
    output logic [RA_W-1:0]        rf_w_addr,
    output logic [XLEN-1:0]        rf_w_data,
    input  logic [NUM_BY*RA_W-1:0] by_raddr,
    output logic [NUM_BY-1:0]      by_hit,
    output logic [NUM_BY*XLEN-1:0] by_data,
    output logic [31:0]            retire_cnt,
    output logic [31:0]            debug_wb_pc,
    output logic [3:0]             debug_wb_rf_wen,
    output logic [4:0]             debug_wb_rf_wnum,
    output logic [31:0]            debug_wb_rf_wdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Same field layout as wb_entry_t, at this instance's widths.
    typedef struct packed {
        logic [31:0]     pc;
        logic            w_en;
        logic [RA_W-1:0] addr;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t           entry_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [31:0]      retire_cnt_reg;

    logic [XLEN-1:0]  ld_data;
    entry_t           in_entry;
    entry_t           head;
    logic             not_empty;
    logic             retire;
    logic             enq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    wb_load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .rdata       (in_ram_rdata),
        .size        (in_ld_size),
        .ld_unsigned (in_ld_unsigned),
        .offset      (in_ld_offset),
        .data        (ld_data)
    );

    // r0 entries keep flowing (they retire and count) but never write and
    // carry zero data, so they can never satisfy a bypass lookup.
    always_comb begin
        in_entry.pc   = in_pc;
        in_entry.addr = in_rf_w_addr;
        in_entry.w_en = in_rf_w_en & (in_rf_w_addr != '0);
        if (in_rf_w_addr == '0) begin
            in_entry.data = '0;
        end else if (in_sel_ram) begin
            in_entry.data = ld_data;
        end else begin
            in_entry.data = in_alu_result;
        end
    end

    assign not_empty   = (count_reg != '0);
    assign retire      = not_empty & rf_w_ready;
    // A full buffer can still accept when its head leaves this cycle.
    assign wb_allow_in = (count_reg < CNT_W'(DEPTH)) | retire;
    assign enq         = mem_to_wb_valid & wb_allow_in;
    assign head        = entry_mem[rd_ptr_reg];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            retire_cnt_reg <= '0;
        end else begin
            if (enq) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (retire) begin
                rd_ptr_reg     <= ptr_inc(rd_ptr_reg);
                retire_cnt_reg <= retire_cnt_reg + 32'd1;
            end
            if (enq && !retire) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (!enq && retire) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Entry storage needs no reset: validity is carried by the pointers
    // and count alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            entry_mem[wr_ptr_reg] <= in_entry;
        end
    end

    assign rf_w_en    = retire & head.w_en;
    assign rf_w_addr  = not_empty ? head.addr : '0;
    assign rf_w_data  = not_empty ? head.data : '0;
    assign retire_cnt = retire_cnt_reg;

    assign debug_wb_pc       = retire ? head.pc : 32'd0;
    assign debug_wb_rf_wen   = {4{rf_w_en}};
    assign debug_wb_rf_wnum  = 5'(rf_w_addr);
    assign debug_wb_rf_wdata = 32'(rf_w_data);

    // Each query walks the live entries oldest to youngest; the last match
    // wins, which gives the youngest value. The retiring head is still live.
    for (genvar gi = 0; gi < NUM_BY; gi++) begin : g_bypass
        logic [RA_W-1:0]  query;
        logic             hit;
        logic [XLEN-1:0]  hit_data;
        int               idx;
        logic [PTR_W-1:0] idx_p;

        assign query = by_raddr[gi*RA_W +: RA_W];

        always_comb begin
            hit      = 1'b0;
            hit_data = '0;
            idx      = 0;
            idx_p    = '0;
            for (int k = 0; k < DEPTH; k++) begin
                idx = int'(rd_ptr_reg) + k;
                if (idx >= DEPTH) begin
                    idx = idx - DEPTH;
                end
                idx_p = PTR_W'(idx);
                if ((k < int'(count_reg)) && entry_mem[idx_p].w_en &&
                    (entry_mem[idx_p].addr == query) && (query != '0)) begin
                    hit      = 1'b1;
                    hit_data = entry_mem[idx_p].data;
                end
            end
        end

        assign by_hit[gi]                = hit;
        assign by_data[gi*XLEN +: XLEN]  = hit_data;
    end

endmodule

// File: tb/tb_wb_stage_buffered.sv
`timescale 1ns/1ps
module tb_wb_stage_buffered;
    import wb_stage_buffered_pkg::*;

    localparam int XLEN   = 32;
    localparam int RA_W   = 5;
    localparam int DEPTH  = 2;
    localparam int NUM_BY = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   mem_to_wb_valid;
    logic                   wb_allow_in;
    logic [31:0]            in_pc;
    logic                   in_rf_w_en;
    logic [RA_W-1:0]        in_rf_w_addr;
    logic                   in_sel_ram;
    logic [XLEN-1:0]        in_alu_result;
    logic [XLEN-1:0]        in_ram_rdata;
    logic [1:0]             in_ld_size;
    logic                   in_ld_unsigned;
    logic [1:0]             in_ld_offset;
    logic                   rf_w_ready = 1'b0;
    logic                   rf_w_en;
    logic [RA_W-1:0]        rf_w_addr;
    logic [XLEN-1:0]        rf_w_data;
    logic [NUM_BY*RA_W-1:0] by_raddr = '0;
    logic [NUM_BY-1:0]      by_hit;
    logic [NUM_BY*XLEN-1:0] by_data;
    logic [31:0]            retire_cnt;
    logic [31:0]            debug_wb_pc;
    logic [3:0]             debug_wb_rf_wen;
    logic [4:0]             debug_wb_rf_wnum;
    logic [31:0]            debug_wb_rf_wdata;

    always #5 clk = ~clk;

    wb_stage_buffered #(
        .XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .NUM_BY(NUM_BY)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .wb_allow_in       (wb_allow_in),
        .in_pc             (in_pc),
        .in_rf_w_en        (in_rf_w_en),
        .in_rf_w_addr      (in_rf_w_addr),
        .in_sel_ram        (in_sel_ram),
        .in_alu_result     (in_alu_result),
        .in_ram_rdata      (in_ram_rdata),
        .in_ld_size        (in_ld_size),
        .in_ld_unsigned    (in_ld_unsigned),
        .in_ld_offset      (in_ld_offset),
        .rf_w_ready        (rf_w_ready),
        .rf_w_en           (rf_w_en),
        .rf_w_addr         (rf_w_addr),
        .rf_w_data         (rf_w_data),
        .by_raddr          (by_raddr),
        .by_hit            (by_hit),
        .by_data           (by_data),
        .retire_cnt        (retire_cnt),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    int          total = 0;
    int          bad = 0;
    wb_entry_t   exp_q[$];
    logic [31:0] model_cnt = 32'd0;
    int          acc_cnt = 0;
    int          stall_cnt = 0;
    int          ready_mode = 1;      // 0 low, 1 high, 2 random
    bit          by_rand = 1'b0;
    logic [4:0]  by_fix0 = 5'd0;
    logic [4:0]  by_fix1 = 5'd0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference load semantics written as plain shifts and masks.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] off);
        logic [31:0] v;
        if (sz == LD_B) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == LD_H) begin
            v = (w >> (16 * off[1])) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Drives rf_w_ready and bypass query addresses at every falling edge.
    always begin
        @(negedge clk);
        case (ready_mode)
            0:       rf_w_ready = 1'b0;
            1:       rf_w_ready = 1'b1;
            default: rf_w_ready = 1'($urandom_range(0, 1));
        endcase
        if (by_rand) by_raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        else         by_raddr = {by_fix1, by_fix0};
    end

    // Push side of the scoreboard: records every accepted instruction.
    always begin
        wb_entry_t e;
        @(negedge clk);
        #2;
        if (!reset && mem_to_wb_valid && wb_allow_in) begin
            e.pc   = in_pc;
            e.addr = in_rf_w_addr;
            e.w_en = in_rf_w_en && (in_rf_w_addr != 5'd0);
            if (in_rf_w_addr == 5'd0)  e.data = 32'd0;
            else if (in_sel_ram)       e.data = ref_load(in_ram_rdata, in_ld_size, in_ld_unsigned, in_ld_offset);
            else                       e.data = in_alu_result;
            exp_q.push_back(e);
            acc_cnt++;
        end
    end

    // Pop side: compares the DUT's view of the buffer head every cycle.
    always begin
        int          n;
        bit          ret;
        logic [4:0]  q;
        bit          eh;
        logic [31:0] ed;
        wb_entry_t   h;
        @(negedge clk);
        #1;
        if (reset) begin
            exp_q.delete();
            model_cnt = 32'd0;
        end else begin
            n   = exp_q.size();
            ret = (n != 0) && rf_w_ready;
            check("allow_in", wb_allow_in, (n < DEPTH) || ret);
            check("retire_cnt", retire_cnt, model_cnt);
            for (int p = 0; p < NUM_BY; p++) begin
                q  = by_raddr[p*RA_W +: RA_W];
                eh = 1'b0;
                ed = 32'd0;
                foreach (exp_q[k]) begin
                    if (exp_q[k].w_en && exp_q[k].addr == q && q != 5'd0) begin
                        eh = 1'b1;
                        ed = exp_q[k].data;
                    end
                end
                check("bypass", {by_hit[p], by_data[p*XLEN +: XLEN]}, {eh, ed});
            end
            if (n != 0) begin
                h = exp_q[0];
                check("head_wr", {rf_w_en, rf_w_addr, rf_w_data}, {ret && h.w_en, h.addr, h.data});
                check("debug", {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata},
                      {(ret ? h.pc : 32'd0), {4{ret && h.w_en}}, h.addr, h.data});
                if (ret) begin
                    $display("retire pc=%08h w_en=%0d addr=%0d data=%08h", h.pc, h.w_en, h.addr, h.data);
                    void'(exp_q.pop_front());
                    model_cnt = model_cnt + 32'd1;
                end
            end else begin
                check("idle_out", {rf_w_en, rf_w_addr, rf_w_data, debug_wb_pc, debug_wb_rf_wen}, 128'd0);
            end
        end
    end

    task automatic send(input logic [31:0] pc, input logic wen, input logic [4:0] addr,
                        input logic sel, input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [1:0] sz, input logic uns, input logic [1:0] off);
        int start;
        int waited;
        @(negedge clk);
        in_pc = pc; in_rf_w_en = wen; in_rf_w_addr = addr; in_sel_ram = sel;
        in_alu_result = alu; in_ram_rdata = rdata; in_ld_size = sz;
        in_ld_unsigned = uns; in_ld_offset = off;
        mem_to_wb_valid = 1'b1;
        start = acc_cnt;
        waited = 0;
        #3;
        while (acc_cnt == start && waited < 50) begin
            @(negedge clk);
            #3;
            waited++;
        end
        stall_cnt += waited;
        if (acc_cnt == start) check("send_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        mem_to_wb_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        ready_mode = 1;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ld_rdata;
    logic [1:0]  ld_sz  [5];
    logic        ld_uns [5];
    logic [1:0]  ld_off [5];
    logic [31:0] ld_exp [5];
    logic [31:0] cnt0;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_to_wb_valid = 1'b0;
        in_pc = '0; in_rf_w_en = 1'b0; in_rf_w_addr = '0; in_sel_ram = 1'b0;
        in_alu_result = '0; in_ram_rdata = '0; in_ld_size = '0;
        in_ld_unsigned = 1'b0; in_ld_offset = '0;
        repeat (2) @(negedge clk);
        #3;
        check("rst_allow", wb_allow_in, 1'b1);
        check("rst_outs", {rf_w_en, retire_cnt, by_hit, debug_wb_pc}, 128'd0);
        @(negedge clk);
        reset = 1'b0;

        // Load extraction against fixed expected words.
        ld_rdata = 32'h8081_F27F;
        ld_sz  = '{LD_B, LD_B, LD_H, LD_H, LD_W};
        ld_uns = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        ld_off = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd0};
        ld_exp = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_8081, 32'hFFFF_F27F, 32'h8081_F27F};
        for (int i = 0; i < 5; i++) begin
            send(32'h40 + 32'(i * 4), 1'b1, 5'd3, 1'b1, 32'h0, ld_rdata, ld_sz[i], ld_uns[i], ld_off[i]);
            @(negedge clk);
            #3;
            check($sformatf("load_%0d", i), rf_w_data, ld_exp[i]);
        end
        drain();

        // Backpressure: two fill the buffer, the third waits for a retire.
        ready_mode = 0;
        send(32'h100, 1'b1, 5'd1, 1'b0, 32'hA1, 32'h0, LD_W, 1'b0, 2'd0);
        send(32'h104, 1'b1, 5'd2, 1'b0, 32'hA2, 32'h0, LD_W, 1'b0, 2'd0);
        @(negedge clk);
        in_pc = 32'h108; in_rf_w_en = 1'b1; in_rf_w_addr = 5'd3; in_sel_ram = 1'b0;
        in_alu_result = 32'hA3; mem_to_wb_valid = 1'b1;
        cnt0 = 32'(acc_cnt);
        #3;
        check("bp_full_allow", wb_allow_in, 1'b0);
        ready_mode = 1;
        @(negedge clk);
        #3;
        check("bp_retire_allow", wb_allow_in, 1'b1);
        check("bp_third_taken", 32'(acc_cnt), cnt0 + 32'd1);
        @(posedge clk);
        #1;
        mem_to_wb_valid = 1'b0;
        drain();

        // Bypass picks the youngest r5; then reset with both entries held.
        ready_mode = 0;
        send(32'h200, 1'b1, 5'd5, 1'b0, 32'h11, 32'h0, LD_W, 1'b0, 2'd0);
        send(32'h204, 1'b1, 5'd5, 1'b0, 32'h22, 32'h0, LD_W, 1'b0, 2'd0);
        by_fix0 = 5'd5;
        by_fix1 = 5'd6;
        @(negedge clk);
        #3;
        check("by_r5", {by_hit[0], by_data[31:0]}, {1'b1, 32'h22});
        check("by_r6", {by_hit[1], by_data[63:32]}, {1'b0, 32'h0});
        by_fix0 = 5'd0;
        @(negedge clk);
        #3;
        check("by_r0", by_hit[0], 1'b0);
        by_fix0 = 5'd5;
        ready_mode = 1;
        @(negedge clk);
        reset = 1'b1;
        #3;
        check("midrst_wen", rf_w_en, 1'b0);
        check("midrst_allow", wb_allow_in, 1'b1);
        check("midrst_cnt_hit", {retire_cnt, by_hit}, 34'd0);
        @(negedge clk);
        reset = 1'b0;
        by_fix0 = 5'd0;

        // r0 write still retires and counts.
        send(32'h300, 1'b1, 5'd0, 1'b0, 32'hDEAD, 32'h0, LD_W, 1'b0, 2'd0);
        @(negedge clk);
        #3;
        check("r0_wen", rf_w_en, 1'b0);
        check("r0_pc", debug_wb_pc, 32'h300);
        @(posedge clk);
        #1;
        check("r0_cnt", retire_cnt, 32'd1);

        // Streaming: 100 back-to-back instructions with no stall.
        drain();
        cnt0 = model_cnt;
        stall_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            send(32'h1000 + 32'(i * 4), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        check("stream_stalls", stall_cnt, 0);
        drain();
        check("stream_cnt", retire_cnt, cnt0 + 32'd100);

        // Random traffic with random readiness and bypass queries.
        ready_mode = 2;
        by_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(32'h8000 + 32'(i * 4), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
